// File: rtl/rob_ctrl.sv
// rob_ctrl: reorder-buffer head/tail pointers, dual in-order commit select and flush sequencing.
// Optional performance counters are compiled in when ROB_PERF_CNT_EN is defined.
module rob_ctrl #(
    parameter int ROB_DEPTH      = 16,
    parameter int PTR_W          = $clog2(ROB_DEPTH),
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 enq_valid,
    output logic                 enq_ready,
    output logic [PTR_W:0]       enq_robidx,
    output logic [ROB_DEPTH-1:0] entry_enq_valid,
    input  logic [ROB_DEPTH-1:0] entry_ready_to_commit,
    output logic [ROB_DEPTH-1:0] entry_commit_vld,
    output logic [1:0]           commit_valid,
    output logic [PTR_W-1:0]     commit_robidx0,
    output logic [PTR_W-1:0]     commit_robidx1,
    input  logic                 flush_req,
    output logic                 flush_vld,
    output logic [PTR_W:0]       rob_count,
    output logic                 rob_full,
    output logic                 rob_empty
`ifdef ROB_PERF_CNT_EN
    ,
    output logic [31:0]          perf_commit_cnt,
    output logic [31:0]          perf_full_stall_cnt
`endif
);
    typedef enum logic [1:0] {RUN, FLUSH, RECOVER} state_t;

    localparam logic [ROB_DEPTH-1:0] ONE = {{(ROB_DEPTH-1){1'b0}}, 1'b1};

    state_t           state;
    logic [3:0]       recover_cnt;
    logic [PTR_W:0]   head;
    logic [PTR_W:0]   tail;
    logic [PTR_W-1:0] head_idx;
    logic [PTR_W-1:0] head_nxt_idx;
    logic [PTR_W-1:0] tail_idx;
    logic [PTR_W:0]   commit_num;
    logic             run;
    logic             enq_fire;
    logic             commit0;
    logic             commit1;

    // Occupancy, handshake and in-order commit selection from the current pointers
    always_comb begin
        head_idx         = head[PTR_W-1:0];
        head_nxt_idx     = head_idx + 1'b1;
        tail_idx         = tail[PTR_W-1:0];
        run              = state == RUN;
        rob_count        = tail - head;
        rob_full         = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
        rob_empty        = head == tail;
        enq_ready        = run & ~rob_full & ~flush_req;
        enq_fire         = enq_valid & enq_ready;
        enq_robidx       = tail;
        entry_enq_valid  = enq_fire ? ONE << tail_idx : '0;
        commit0          = run & ~rob_empty & entry_ready_to_commit[head_idx];
        commit1          = commit0 & (|rob_count[PTR_W:1]) & entry_ready_to_commit[head_nxt_idx];
        commit_valid     = {commit1, commit0};
        commit_robidx0   = commit0 ? head_idx : '0;
        commit_robidx1   = commit1 ? head_nxt_idx : '0;
        entry_commit_vld = (commit0 ? ONE << head_idx : '0) | (commit1 ? ONE << head_nxt_idx : '0);
        commit_num       = {{(PTR_W-1){1'b0}}, commit1, commit0 & ~commit1};
    end

    // Pointer advance and RUN -> FLUSH -> RECOVER -> RUN sequencing; flush_vld is registered
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= RUN;
            recover_cnt <= '0;
            head        <= '0;
            tail        <= '0;
            flush_vld   <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    head <= head + commit_num;
                    tail <= tail + {{PTR_W{1'b0}}, enq_fire};
                    if (flush_req) begin
                        state     <= FLUSH;
                        flush_vld <= 1'b1;
                    end
                end
                FLUSH: begin
                    head        <= '0;
                    tail        <= '0;
                    recover_cnt <= 4'(RECOVER_CYCLES - 1);
                    state       <= flush_req ? FLUSH : RECOVER;
                    flush_vld   <= flush_req;
                end
                default: begin
                    if (flush_req) begin
                        state     <= FLUSH;
                        flush_vld <= 1'b1;
                    end else if (recover_cnt == '0) begin
                        state <= RUN;
                    end else begin
                        recover_cnt <= recover_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef ROB_PERF_CNT_EN
    // Commit and full-stall statistics; only reset clears them, flushes do not
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_commit_cnt     <= '0;
            perf_full_stall_cnt <= '0;
        end else begin
            perf_commit_cnt     <= perf_commit_cnt + 32'(commit_num);
            perf_full_stall_cnt <= perf_full_stall_cnt + {31'b0, enq_valid & rob_full & run};
        end
    end
`endif

endmodule

// File: tb/tb_rob_ctrl.sv
// tb_rob_ctrl: directed vector table plus randomized run against an occupancy-count model of rob_ctrl.
module tb_rob_ctrl;
    localparam int D  = 16;
    localparam int PW = 4;
    localparam int RC = 2;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          enq_valid = 1'b0;
    logic          flush_req = 1'b0;
    logic [D-1:0]  entry_ready_to_commit = '0;
    logic          enq_ready;
    logic [PW:0]   enq_robidx;
    logic [D-1:0]  entry_enq_valid;
    logic [D-1:0]  entry_commit_vld;
    logic [1:0]    commit_valid;
    logic [PW-1:0] commit_robidx0;
    logic [PW-1:0] commit_robidx1;
    logic          flush_vld;
    logic [PW:0]   rob_count;
    logic          rob_full;
    logic          rob_empty;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: absolute allocate/commit counts, mode 0 run / 1 flush / 2 recover, recover cycles left
    int mh = 0;
    int mt = 0;
    int mmode = 0;
    int mrc = 0;

    typedef struct {
        logic          ev;
        logic          fr;
        logic [D-1:0]  rdy;
        logic          ready;
        logic [PW:0]   cnt;
        logic [1:0]    cv;
        logic          fl;
        logic [PW:0]   idx;
        logic [D-1:0]  eev;
        logic [D-1:0]  ecv;
        logic [PW-1:0] i0;
        logic [PW-1:0] i1;
    } vec_t;

    vec_t tv[$];

    rob_ctrl #(.ROB_DEPTH(D), .RECOVER_CYCLES(RC)) dut (
        .clock                 (clock),
        .reset_n               (reset_n),
        .enq_valid             (enq_valid),
        .enq_ready             (enq_ready),
        .enq_robidx            (enq_robidx),
        .entry_enq_valid       (entry_enq_valid),
        .entry_ready_to_commit (entry_ready_to_commit),
        .entry_commit_vld      (entry_commit_vld),
        .commit_valid          (commit_valid),
        .commit_robidx0        (commit_robidx0),
        .commit_robidx1        (commit_robidx1),
        .flush_req             (flush_req),
        .flush_vld             (flush_vld),
        .rob_count             (rob_count),
        .rob_full              (rob_full),
        .rob_empty             (rob_empty)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(int ev, int rdy, int fr, int ready, int cnt, int cv, int fl,
                                int idx, int eev, int ecv, int i0, int i1);
        vec_t v;
        v.ev = ev[0];
        v.rdy = D'(rdy);
        v.fr = fr[0];
        v.ready = ready[0];
        v.cnt = (PW+1)'(cnt);
        v.cv = 2'(cv);
        v.fl = fl[0];
        v.idx = (PW+1)'(idx);
        v.eev = D'(eev);
        v.ecv = D'(ecv);
        v.i0 = PW'(i0);
        v.i1 = PW'(i1);
        tv.push_back(v);
    endfunction

    task automatic chk_reset(input string tag);
        chk({tag, " enq_ready"}, 32'(enq_ready), 1);
        chk({tag, " rob_empty"}, 32'(rob_empty), 1);
        chk({tag, " rob_full"}, 32'(rob_full), 0);
        chk({tag, " rob_count"}, 32'(rob_count), 0);
        chk({tag, " enq_robidx"}, 32'(enq_robidx), 0);
        chk({tag, " flush_vld"}, 32'(flush_vld), 0);
        chk({tag, " commit_valid"}, 32'(commit_valid), 0);
        chk({tag, " entry_enq_valid"}, 32'(entry_enq_valid), 0);
        chk({tag, " entry_commit_vld"}, 32'(entry_commit_vld), 0);
        chk({tag, " commit_robidx0"}, 32'(commit_robidx0), 0);
        chk({tag, " commit_robidx1"}, 32'(commit_robidx1), 0);
    endtask

    // Evaluate the spec rules for the current cycle, optionally compare, then advance the model
    task automatic model_step(input bit do_chk);
        int  cnt   = mt - mh;
        bit  run   = (mmode == 0);
        bit  full  = (cnt == D);
        bit  rdy_e = run && !full && !flush_req;
        bit  fire  = enq_valid && rdy_e;
        bit  c0    = run && cnt >= 1 && entry_ready_to_commit[mh % D];
        bit  c1    = c0 && cnt >= 2 && entry_ready_to_commit[(mh + 1) % D];
        int  eev   = fire ? (1 << (mt % D)) : 0;
        int  ecv   = (c0 ? (1 << (mh % D)) : 0) | (c1 ? (1 << ((mh + 1) % D)) : 0);
        if (do_chk) begin
            chk("m enq_ready", 32'(enq_ready), 32'(rdy_e));
            chk("m rob_count", 32'(rob_count), cnt);
            chk("m rob_full", 32'(rob_full), 32'(full));
            chk("m rob_empty", 32'(rob_empty), 32'(cnt == 0));
            chk("m flush_vld", 32'(flush_vld), 32'(mmode == 1));
            chk("m commit_valid", 32'(commit_valid), {30'b0, c1, c0});
            chk("m entry_enq_valid", 32'(entry_enq_valid), eev);
            chk("m entry_commit_vld", 32'(entry_commit_vld), ecv);
            if (rdy_e) chk("m enq_robidx", 32'(enq_robidx), mt % (2 * D));
            if (c0) chk("m commit_robidx0", 32'(commit_robidx0), mh % D);
            if (c1) chk("m commit_robidx1", 32'(commit_robidx1), (mh + 1) % D);
        end
        if (mmode == 0) begin
            mh = mh + int'(c0) + int'(c1);
            mt = mt + int'(fire);
            if (flush_req) mmode = 1;
        end else if (mmode == 1) begin
            mh = 0;
            mt = 0;
            if (!flush_req) begin
                mmode = 2;
                mrc = RC;
            end
        end else if (flush_req) begin
            mmode = 1;
        end else begin
            mrc--;
            if (mrc == 0) mmode = 0;
        end
    endtask

    task automatic model_reset();
        mh = 0;
        mt = 0;
        mmode = 0;
        mrc = 0;
    endtask

    initial begin
        // Directed table: fill, dual commit, blocked commit, flush window, pointer wrap
        for (int i = 0; i < D; i++) add(1, 0, 0, 1, i, 0, 0, i, 1 << i, 0, 0, 0);
        add(1, 0, 0, 0, 16, 0, 0, 16, 0, 0, 0, 0);
        add(1, 'h0003, 0, 0, 16, 3, 0, 16, 0, 'h0003, 0, 1);
        add(0, 0, 0, 1, 14, 0, 0, 16, 0, 0, 0, 0);
        add(0, 'h000C, 0, 1, 14, 3, 0, 16, 0, 'h000C, 2, 3);
        add(0, 'h0020, 0, 1, 12, 0, 0, 16, 0, 0, 0, 0);
        add(0, 'h0030, 0, 1, 12, 3, 0, 16, 0, 'h0030, 4, 5);
        add(0, 'h00C0, 0, 1, 10, 3, 0, 16, 0, 'h00C0, 6, 7);
        add(0, 'h0300, 0, 1, 8, 3, 0, 16, 0, 'h0300, 8, 9);
        add(0, 'h0400, 0, 1, 6, 1, 0, 16, 0, 'h0400, 10, 0);
        add(1, 0, 1, 0, 5, 0, 0, 16, 0, 0, 0, 0);
        add(1, 'hFFFF, 0, 0, 5, 0, 1, 16, 0, 0, 0, 0);
        add(1, 'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 'hFFFF, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < D - 1; i++) add(1, 0, 0, 1, i, 0, 0, i, 1 << i, 0, 0, 0);
        for (int k = 0; k < 7; k++) add(0, 'h7FFF, 0, 1, 15 - 2 * k, 3, 0, 15, 0, 3 << (2 * k), 2 * k, 2 * k + 1);
        add(0, 'h7FFF, 0, 1, 1, 1, 0, 15, 0, 'h4000, 14, 0);
        add(1, 0, 0, 1, 0, 0, 0, 15, 'h8000, 0, 0, 0);
        add(1, 0, 0, 1, 1, 0, 0, 16, 'h0001, 0, 0, 0);
        add(0, 'h8001, 0, 1, 2, 3, 0, 17, 0, 'h8001, 15, 0);
        add(0, 0, 0, 1, 0, 0, 0, 17, 0, 0, 0, 0);

        #2;
        chk_reset("reset");
        #10 reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk_reset("idle");

        foreach (tv[i]) begin
            enq_valid = tv[i].ev;
            entry_ready_to_commit = tv[i].rdy;
            flush_req = tv[i].fr;
            @(negedge clock);
            chk("t enq_ready", 32'(enq_ready), 32'(tv[i].ready));
            chk("t rob_count", 32'(rob_count), 32'(tv[i].cnt));
            chk("t rob_full", 32'(rob_full), 32'(tv[i].cnt == 5'd16));
            chk("t rob_empty", 32'(rob_empty), 32'(tv[i].cnt == 5'd0));
            chk("t flush_vld", 32'(flush_vld), 32'(tv[i].fl));
            chk("t commit_valid", 32'(commit_valid), 32'(tv[i].cv));
            chk("t entry_enq_valid", 32'(entry_enq_valid), 32'(tv[i].eev));
            chk("t entry_commit_vld", 32'(entry_commit_vld), 32'(tv[i].ecv));
            if (tv[i].ready) chk("t enq_robidx", 32'(enq_robidx), 32'(tv[i].idx));
            if (tv[i].cv[0]) chk("t commit_robidx0", 32'(commit_robidx0), 32'(tv[i].i0));
            if (tv[i].cv[1]) chk("t commit_robidx1", 32'(commit_robidx1), 32'(tv[i].i1));
            model_step(1'b1);
            @(posedge clock);
            #1;
        end

        // Held flush_req loops FLUSH/RECOVER, then releases into a normal recovery window
        for (int i = 0; i < 8; i++) begin
            enq_valid = 1'b1;
            entry_ready_to_commit = '1;
            flush_req = (i < 4);
            @(negedge clock);
            model_step(1'b1);
            @(posedge clock);
            #1;
        end

        // Randomized traffic with occasional flushes and mid-cycle asynchronous resets
        for (int r = 0; r < 4; r++) begin
            for (int n = 0; n < 700; n++) begin
                enq_valid = ($urandom_range(0, 3) != 0);
                entry_ready_to_commit = ($urandom_range(0, 2) == 0) ? '0 : D'($urandom);
                flush_req = ($urandom_range(0, 60) == 0);
                @(negedge clock);
                model_step(1'b1);
                @(posedge clock);
                #1;
            end
            #1 reset_n = 1'b0;
            flush_req = 1'b0;
            enq_valid = 1'b0;
            entry_ready_to_commit = '0;
            #1;
            chk_reset("async reset");
            model_reset();
            #3 reset_n = 1'b1;
            @(posedge clock);
            #1;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rob_ctrl.md
Name: rob_ctrl

Overview:
- Controls a circular reorder buffer built from ROB_DEPTH per-entry instances.
- Owns the head (commit) and tail (allocate) pointers.
- Issues one-hot enqueue strobes to entries and selects up to two in-order commits per cycle from the entries' ready_to_commit flags.
- Sequences pipeline flush: one-cycle broadcast flush, then a fixed recovery window.
- Sits in the backend issue stage, between rename/dispatch and the entry array.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of two, minimum 4.
- PTR_W, $clog2(ROB_DEPTH), entry index width.
- RECOVER_CYCLES, 2, enqueue-blocked cycles after the flush cycle; range 1..15.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- enq_valid  in  1  dispatch offers one instruction.
- enq_ready  out  1  ROB accepts this cycle.
- enq_robidx  out  PTR_W+1  {wrap, index} of the current tail, valid when enq_ready is 1.
- entry_enq_valid  out  ROB_DEPTH  one-hot allocate strobe to entries.
- entry_ready_to_commit  in  ROB_DEPTH  per-entry valid & complete.
- entry_commit_vld  out  ROB_DEPTH  per-entry commit strobe; 0, 1 or 2 bits set.
- commit_valid  out  2  bit0 = oldest commit slot, bit1 = second slot.
- commit_robidx0  out  PTR_W  index committed in slot 0.
- commit_robidx1  out  PTR_W  index committed in slot 1.
- flush_req  in  1  redirect request from the execute stage.
- flush_vld  out  1  broadcast flush to all entries.
- rob_count  out  PTR_W+1  occupied entries, 0..ROB_DEPTH.
- rob_full  out  1  rob_count == ROB_DEPTH.
- rob_empty  out  1  rob_count == 0.

Behaviour:
- Reset:
  - head = tail = 0, including wrap bits.
  - State RUN, recovery counter 0.
  - Every output is 0 except enq_ready = 1 and rob_empty = 1.
- Pointers:
  - head and tail are PTR_W+1 bits; the MSB is the wrap bit.
  - rob_count = tail - head, modulo 2*ROB_DEPTH.
  - Full when the indexes are equal and the wrap bits differ.
  - Empty when head == tail.
- States:
  - RUN: enq_ready = ~rob_full & ~flush_req, combinational.
  - FLUSH: exactly one cycle. flush_vld = 1, enq_ready = 0, no commits. On exit, head = tail = 0 and the counter is loaded with RECOVER_CYCLES-1. Next state is RECOVER.
  - RECOVER: enq_ready = 0, no commits. The counter decrements each cycle; on the cycle it reads 0, the next state is RUN.
  - RUN to FLUSH on flush_req = 1.
- Enqueue:
  - Handshake completes when enq_valid & enq_ready.
  - In that cycle entry_enq_valid[tail index] = 1 and the tail advances by 1 at the clock edge.
  - The index wraps ROB_DEPTH-1 -> 0 and the wrap bit toggles.
- Commit (RUN only, including the flush_req cycle, since older instructions retire):
  - Slot 0 fires if rob_count >= 1 and entry_ready_to_commit[head] = 1.
  - Slot 1 fires only if slot 0 fires, rob_count >= 2 and entry_ready_to_commit[head+1 mod ROB_DEPTH] = 1. Strictly in order: slot 1 never fires alone.
  - The head advances by popcount(commit_valid). Wrap is handled as for the tail.
- Simultaneous enqueue and commit: rob_count changes by +1 - commits. A full ROB with a commit still reports enq_ready = 0 that cycle; there is no bypass.
- flush_req while in FLUSH or RECOVER: re-enters FLUSH next cycle and restarts the sequence.
- A flush_req held high keeps looping FLUSH/RECOVER.
- Asynchronous reset at any point returns to the reset state immediately.

Optional Feature:
- Macro: ROB_PERF_CNT_EN.
- When defined, two extra output ports, both cleared on reset only (a flush does not clear them):
  - perf_commit_cnt [31:0]: accumulates popcount(commit_valid) each cycle, wrapping.
  - perf_full_stall_cnt [31:0]: increments on cycles with enq_valid & rob_full & state == RUN.
- When undefined, both ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then idle -> rob_count 0, rob_empty 1, enq_ready 1, flush_vld 0, commit_valid 00, all strobes 0.
- 16 back-to-back enqueues with no completions -> enq_robidx 0..15; entry_enq_valid one-hot 0x0001..0x8000; after the 16th, rob_full 1, enq_ready 0; tail = {1, 0}.
- Full ROB, entry_ready_to_commit = 0x0003 -> one cycle with commit_valid 11, idx0 = 0, idx1 = 1, entry_commit_vld 0x0003; next cycle rob_count 14, enq_ready 1.
- Head = 4, entry_ready_to_commit bit4 = 0, bit5 = 1 -> commit_valid 00, head unchanged; then set bit4 -> commit_valid 11.
- rob_count 5, pulse flush_req for 1 cycle -> flush_vld = 1 exactly the next cycle; enq_ready 0 for 3 cycles total (FLUSH + 2 RECOVER); then rob_count 0, head = tail = 0, enq_ready 1.
- Head at index 15 (wrap 0), tail at index 1 (wrap 1), bits 15 and 0 ready -> commit_robidx0 = 15, commit_robidx1 = 0; head becomes {1, 1}; rob_count 0.
